adc_sample_averager: RTL and testbench

Consumes 12-bit conversions from the MCP3202 SPI master (its o_DATA/DATA_VALID outputs) and produces a boxcar average over 2^LOG2_N samples, then decimates by the same factor. The result is held in an output register with a valid/ready handshake. The downstream consumer is the MCP4822 DAC SPI master or other processing logic. The block is single-clock and runs in the same clk domain as the ADC master (125 MHz).

---
 rtl/adc_avg_pkg.sv | 23 ++
 rtl/avg_out_hold.sv | 51 +++++
 rtl/adc_sample_averager.sv | 122 ++++++++++++
 tb/tb_adc_sample_averager.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/adc_avg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : adc_avg_pkg                                                |
// | Desc    : Shared widths, FSM state type and sizing helper for the    |
// |           ADC sample averager.                                       |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
package adc_avg_pkg;

  localparam int ADC_DATA_W = 12;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } avg_state_t;

  // The sum of 2^log2_n samples fits exactly in data_w + log2_n bits
  function automatic int acc_width(input int data_w, input int log2_n);
    return data_w + log2_n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/avg_out_hold.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : avg_out_hold                                               |
// | Desc    : Result holding register with valid/ready handshake and a   |
// |           sticky overrun flag for unaccepted, overwritten results.   |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
module avg_out_hold #(
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              i_READY,
  output logic [DATA_W-1:0] o_DATA,
  output logic              o_VALID,
  output logic              o_OVERRUN
);

  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_overrun;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (clear) begin
      // Data is deliberately kept so the last result stays visible
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (load) begin
      r_data  <= load_data;
      r_valid <= 1'b1;
      if (r_valid && !i_READY) begin
        r_overrun <= 1'b1;
      end
    end else if (r_valid && i_READY) begin
      r_valid <= 1'b0;
    end
  end

  assign o_DATA    = r_data;
  assign o_VALID   = r_valid;
  assign o_OVERRUN = r_overrun;

endmodule
`default_nettype wire

// File: rtl/adc_sample_averager.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : adc_sample_averager                                        |
// | Desc    : Boxcar average of 2^LOG2_N ADC samples, decimated by the   |
// |           same factor. Define AVG_ROUND_EN for round-half-up result. |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
module adc_sample_averager
  import adc_avg_pkg::*;
#(
  parameter int DATA_W = ADC_DATA_W,
  parameter int LOG2_N = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              EN,
  input  logic [DATA_W-1:0] i_DATA,
  input  logic              i_VALID,
  output logic [DATA_W-1:0] o_DATA,
  output logic              o_VALID,
  input  logic              i_READY,
  output logic              o_OVERRUN
);

  localparam int c_acc_w = acc_width(DATA_W, LOG2_N);
  localparam int c_cnt_w = (LOG2_N > 0) ? LOG2_N : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'((1 << LOG2_N) - 1);
`ifdef AVG_ROUND_EN
  localparam logic [c_acc_w-1:0] c_round = c_acc_w'((1 << LOG2_N) >> 1);
`else
  localparam logic [c_acc_w-1:0] c_round = '0;
`endif

  avg_state_t         r_state;
  avg_state_t         w_state_nxt;
  logic [c_acc_w-1:0] r_acc;
  logic [c_acc_w-1:0] w_acc_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic               r_valid_q;
  logic               w_strobe;
  logic [c_acc_w-1:0] w_sum;
  logic [DATA_W-1:0]  w_result;
  logic               w_load;
  logic               w_clear;

  // A held DATA_VALID level produces a single strobe on its rising edge
  assign w_strobe = i_VALID & ~r_valid_q;
  assign w_sum    = r_acc + c_acc_w'(i_DATA) + c_round;
  assign w_result = DATA_W'(w_sum >> LOG2_N);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_valid_q <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_acc     <= w_acc_nxt;
      r_cnt     <= w_cnt_nxt;
      r_valid_q <= i_VALID;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      IDLE: begin
        w_clear   = 1'b1;
        w_acc_nxt = '0;
        w_cnt_nxt = '0;
        if (EN) begin
          w_state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (w_strobe) begin
          if (r_cnt == c_last) begin
            w_load    = 1'b1;
            w_acc_nxt = '0;
            w_cnt_nxt = '0;
          end else begin
            w_acc_nxt = r_acc + c_acc_w'(i_DATA);
            w_cnt_nxt = r_cnt + c_cnt_w'(1);
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    // Disable wins over everything, including a completing strobe
    if (!EN) begin
      w_state_nxt = IDLE;
      w_acc_nxt   = '0;
      w_cnt_nxt   = '0;
      w_load      = 1'b0;
      w_clear     = 1'b1;
    end
  end

  avg_out_hold #(
    .DATA_W(DATA_W)
  ) u_out_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (w_clear),
    .load      (w_load),
    .load_data (w_result),
    .i_READY   (i_READY),
    .o_DATA    (o_DATA),
    .o_VALID   (o_VALID),
    .o_OVERRUN (o_OVERRUN)
  );

endmodule
`default_nettype wire

// File: tb/tb_adc_sample_averager.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_adc_sample_averager                                     |
// | Desc    : Directed and random stimulus against a queue-based model.  |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_adc_sample_averager;

  localparam int N_LOG2 = 3;
  localparam int N      = 1 << N_LOG2;
`ifdef AVG_ROUND_EN
  localparam int RND = N / 2;
`else
  localparam int RND = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [11:0] adc_data = '0;
  logic        adc_valid = 1'b0;
  logic        ready = 1'b0;
  logic [11:0] out_data;
  logic        out_valid;
  logic        out_overrun;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int          q[$];
  bit          m_prev_valid = 0;
  bit          m_active = 0;
  logic [11:0] m_data = '0;
  bit          m_valid = 0;
  bit          m_ovr = 0;

  int          pulses = 0;
  logic [11:0] last_seen = '0;

  always #4 clk = ~clk;

  adc_sample_averager #(
    .DATA_W(12),
    .LOG2_N(N_LOG2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .EN        (en),
    .i_DATA    (adc_data),
    .i_VALID   (adc_valid),
    .o_DATA    (out_data),
    .o_VALID   (out_valid),
    .i_READY   (ready),
    .o_OVERRUN (out_overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock of the averaging behaviour, evaluated on the inputs seen at the edge
  task automatic model_step();
    bit strobe;
    bit new_res;
    int sum;
    strobe = adc_valid && !m_prev_valid;
    if (!rst_n) begin
      q.delete();
      m_prev_valid = 0;
      m_active = 0;
      m_data = '0;
      m_valid = 0;
      m_ovr = 0;
      return;
    end
    m_prev_valid = adc_valid;
    if (!en) begin
      q.delete();
      m_active = 0;
      m_valid = 0;
      m_ovr = 0;
    end else if (!m_active) begin
      m_active = 1;
    end else begin
      new_res = 0;
      if (strobe) begin
        q.push_back(int'(adc_data));
        if (q.size() == N) begin
          sum = 0;
          foreach (q[k]) sum += q[k];
          q.delete();
          new_res = 1;
          if (m_valid && !ready) m_ovr = 1;
          m_data = 12'((sum + RND) / N);
          m_valid = 1;
        end
      end
      if (!new_res && m_valid && ready) m_valid = 0;
    end
  endtask

  task automatic tick(input logic v, input logic [11:0] d);
    adc_valid = v;
    adc_data = d;
    @(posedge clk);
    model_step();
    #1;
    check("o_VALID", out_valid, m_valid);
    check("o_DATA", out_data, m_data);
    check("o_OVERRUN", out_overrun, m_ovr);
    if (out_valid) begin
      pulses++;
      last_seen = out_data;
    end
  endtask

  task automatic sample(input logic [11:0] d, input int hold, input int gap);
    for (int i = 0; i < hold; i++) tick(1'b1, d);
    for (int i = 0; i < gap; i++) tick(1'b0, d);
  endtask

  task automatic start_run();
    rst_n = 1'b1;
    en = 1'b1;
    tick(1'b0, '0);
    tick(1'b0, '0);
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    tick(1'b0, 12'hABC);
    tick(1'b0, 12'hABC);
    check("rst_data", out_data, 0);
    check("rst_valid", out_valid, 0);
    check("rst_ovr", out_overrun, 0);

    // Constant average, downstream always ready
    ready = 1'b1;
    start_run();
    pulses = 0;
    for (int i = 0; i < N; i++) sample(12'hD73, 1, 1);
    check("t1_pulses", pulses, 1);
    check("t1_data", last_seen, 12'hD73);

    // Ramp 0..7: truncation gives 3, rounding gives 4
    pulses = 0;
    for (int i = 0; i < N; i++) sample(12'(i), 1, 2);
    check("t2_pulses", pulses, 1);
    check("t2_ramp", last_seen, 12'(3 + (RND != 0 ? 1 : 0)));
    for (int i = 0; i < N; i++) sample(12'hFFF, 2, 1);
    check("t2_full", last_seen, 12'hFFF);

    // Long DATA_VALID levels count once each
    pulses = 0;
    for (int i = 0; i < N; i++) sample(12'h100, 140, 1);
    check("t3_pulses", pulses, 1);
    check("t3_data", last_seen, 12'h100);

    // Two averages with nobody accepting
    ready = 1'b0;
    for (int i = 0; i < N; i++) sample(12'h005, 1, 1);
    for (int i = 0; i < N; i++) sample(12'h009, 1, 1);
    check("t4_data", out_data, 12'h009);
    check("t4_valid", out_valid, 1);
    check("t4_ovr", out_overrun, 1);
    ready = 1'b1;
    tick(1'b0, '0);
    check("t4_accept", out_valid, 0);
    check("t4_ovr_sticky", out_overrun, 1);
    tick(1'b0, '0);
    en = 1'b0;
    tick(1'b0, '0);
    check("t4_ovr_clr", out_overrun, 0);

    // Partial sum discarded by EN drop
    start_run();
    for (int i = 0; i < 5; i++) sample(12'h800, 1, 1);
    en = 1'b0;
    tick(1'b0, '0);
    tick(1'b0, '0);
    en = 1'b1;
    tick(1'b0, '0);
    for (int i = 0; i < N; i++) sample(12'h010, 1, 1);
    check("t5_en_data", last_seen, 12'h010);

    // Same, discarded by reset
    for (int i = 0; i < 5; i++) sample(12'h800, 1, 1);
    rst_n = 1'b0;
    tick(1'b0, '0);
    check("t5_rst_data", out_data, 0);
    check("t5_rst_valid", out_valid, 0);
    tick(1'b0, '0);
    start_run();
    for (int i = 0; i < N; i++) sample(12'h010, 1, 1);
    check("t5_rst_res", last_seen, 12'h010);

    // Accept and new load in the same cycle
    ready = 1'b0;
    for (int i = 0; i < N; i++) sample(12'h020, 1, 1);
    for (int i = 0; i < N - 1; i++) sample(12'h040, 1, 1);
    ready = 1'b1;
    tick(1'b1, 12'h040);
    check("t6_valid", out_valid, 1);
    check("t6_data", out_data, 12'h040);
    check("t6_ovr", out_overrun, 0);
    tick(1'b0, '0);
    check("t6_drain", out_valid, 0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      en = ($urandom_range(0, 149) != 0);
      rst_n = ($urandom_range(0, 599) != 0);
      ready = (i % 1000 < 500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      tick(($urandom_range(0, 2) != 0), 12'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
